// File: rtl/avalon_mem_stream_master_if.sv
// Command, stream and Avalon-MM signal bundle for avalon_mem_stream_master.
// The master modport is the block's view; the slave modport is the opposite side.
interface avalon_mem_stream_master_if #(
    parameter int AW = 12,
    parameter int DW = 64
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    logic          done;

    logic [AW-1:0] avm_address;
    logic [DW-1:0] avm_writedata;
    logic          avm_write;
    logic          avm_read;
    logic [7:0]    avm_byteenable;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_base, cmd_len,
        input  in_valid, in_data, out_ready,
        input  avm_readdata, avm_waitrequest,
        output cmd_ready, in_ready, out_valid, out_data, done,
        output avm_address, avm_writedata, avm_write, avm_read, avm_byteenable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_base, cmd_len,
        output in_valid, in_data, out_ready,
        output avm_readdata, avm_waitrequest,
        input  cmd_ready, in_ready, out_valid, out_data, done,
        input  avm_address, avm_writedata, avm_write, avm_read, avm_byteenable
    );
endinterface

// File: rtl/avalon_mem_stream_master.sv
// Avalon-MM master that loads a word range into the 64-bit RAM from a stream and unloads it back.
// Define MSTR_CHECKSUM_EN to add the csum output (XOR of every word moved by the command).
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR_LO   | taking a stream word, then writing its low half (be 0F)
// WR_HI   | writing the high half (be F0), which commits the word
// RD_REQ  | single-cycle read request at addr
// RD_WAIT | counting down the slave read latency
// RD_OUT  | presenting the read word until the consumer takes it
// DONE    | one-cycle done pulse
module avalon_mem_stream_master #(
    parameter int AW     = 12,
    parameter int DW     = 64,
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    avalon_mem_stream_master_if.master bus
`ifdef MSTR_CHECKSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);
    localparam int LW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam int HW = DW / 2;

    typedef enum logic [2:0] {
        IDLE, WR_LO, WR_HI, RD_REQ, RD_WAIT, RD_OUT, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [AW:0]   cnt;
    logic [DW-1:0] hold;
    logic          held;
    logic [LW-1:0] lat;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          cmd_acc;
    logic          last_word;

    assign cmd_acc       = bus.cmd_valid && (state == IDLE);
    assign last_word     = (cnt == (AW+1)'(1));
    assign bus.out_valid = rvalid;
    assign bus.out_data  = rdata;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.cmd_ready      = 1'b0;
        bus.in_ready       = 1'b0;
        bus.done           = 1'b0;
        bus.avm_write      = 1'b0;
        bus.avm_read       = 1'b0;
        bus.avm_address    = '0;
        bus.avm_writedata  = '0;
        bus.avm_byteenable = 8'h00;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0)  state_nxt = DONE;
                    else if (bus.cmd_write) state_nxt = WR_LO;
                    else                    state_nxt = RD_REQ;
                end
            end
            WR_LO: begin
                bus.in_ready = !held;
                if (held) begin
                    bus.avm_write      = 1'b1;
                    bus.avm_address    = addr;
                    bus.avm_byteenable = 8'h0F;
                    bus.avm_writedata  = {{HW{1'b0}}, hold[HW-1:0]};
                    if (!bus.avm_waitrequest) state_nxt = WR_HI;
                end
            end
            WR_HI: begin
                bus.avm_write      = 1'b1;
                bus.avm_address    = addr;
                bus.avm_byteenable = 8'hF0;
                bus.avm_writedata  = {hold[DW-1:HW], {HW{1'b0}}};
                if (!bus.avm_waitrequest) state_nxt = last_word ? DONE : WR_LO;
            end
            RD_REQ: begin
                bus.avm_read    = 1'b1;
                bus.avm_address = addr;
                if (!bus.avm_waitrequest) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat == LW'(1)) state_nxt = RD_OUT;
            end
            RD_OUT: begin
                if (bus.out_ready) state_nxt = last_word ? DONE : RD_REQ;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address wraps naturally at AW bits when a word completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= '0;
            cnt    <= '0;
            hold   <= '0;
            held   <= 1'b0;
            lat    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_acc) begin
                        addr <= bus.cmd_base;
                        cnt  <= bus.cmd_len;
                    end
                end
                WR_LO: begin
                    if (!held && bus.in_valid) begin
                        hold <= bus.in_data;
                        held <= 1'b1;
                    end
                end
                WR_HI: begin
                    if (!bus.avm_waitrequest) begin
                        held <= 1'b0;
                        cnt  <= cnt - (AW+1)'(1);
                        addr <= addr + AW'(1);
                    end
                end
                RD_REQ: begin
                    if (!bus.avm_waitrequest) lat <= LW'(RD_LAT);
                end
                RD_WAIT: begin
                    lat <= lat - LW'(1);
                    if (lat == LW'(1)) begin
                        rdata  <= bus.avm_readdata;
                        rvalid <= 1'b1;
                    end
                end
                RD_OUT: begin
                    if (bus.out_ready) begin
                        rvalid <= 1'b0;
                        cnt    <= cnt - (AW+1)'(1);
                        addr   <= addr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MSTR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)                                          csum <= '0;
        else if (cmd_acc)                                   csum <= '0;
        else if (state == WR_HI && !bus.avm_waitrequest)    csum <= csum ^ hold;
        else if (state == RD_OUT && bus.out_ready)          csum <= csum ^ rdata;
    end
`else
    // Checksum accumulator is not built in this configuration.
`endif

endmodule

// File: tb/tb_avalon_mem_stream_master.sv
// Randomized bench for avalon_mem_stream_master with a RAM slave model and a word-level reference.
// Build with MSTR_CHECKSUM_EN defined to also check csum.
module tb_avalon_mem_stream_master;
    localparam int AW = 12, DW = 64, RD_LAT = 2;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  be;
        logic [63:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avalon_mem_stream_master_if #(.AW(AW), .DW(DW)) bus();
`ifdef MSTR_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    avalon_mem_stream_master #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MSTR_CHECKSUM_EN
        ,
        .csum  (csum)
`endif
    );

    int n_vec = 0, n_err = 0;
    logic [63:0] slave_mem [4096];
    logic [63:0] ref_mem [4096];
    logic [63:0] in_q[$], exp_out[$], wq[$];
    logic [11:0] exp_rd[$];
    beat_t       exp_beats[$];
    int p_wait, p_in, p_out, stall_n, arm_wait, force_wait;
    int rd_pend = -1, ov_ticks = 0, done_cnt = 0, bus_act = 0;
    bit wr_acc = 0, in_acc = 0, rd_out = 0, hold_q = 0, stall_q = 0;
    logic [11:0] wa, rd_addr;
    logic [7:0]  wbe;
    logic [63:0] wd, prev_out, csum_exp;
    logic [85:0] snap;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: apply last edge's slave effects, drive inputs, then observe what the next edge will do.
    task automatic tick();
        @(negedge clk);
        if (wr_acc)
            for (int b = 0; b < 8; b++)
                if (wbe[b]) slave_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
        if (in_acc && in_q.size() > 0) void'(in_q.pop_front());
        bus.avm_readdata = {$urandom, $urandom};
        if (rd_pend > 0) begin
            rd_pend--;
            if (rd_pend == 0) bus.avm_readdata = slave_mem[rd_addr];
        end
        if (arm_wait > 0 && (bus.avm_write || bus.avm_read)) begin
            force_wait = arm_wait;
            arm_wait   = 0;
        end
        if (force_wait > 0) begin
            bus.avm_waitrequest = 1'b1;
            force_wait--;
        end else begin
            bus.avm_waitrequest = (int'($urandom_range(99)) < p_wait);
        end
        if (!(bus.in_valid && !in_acc)) begin
            if (in_q.size() > 0 && int'($urandom_range(99)) < p_in) begin
                bus.in_valid = 1'b1;
                bus.in_data  = in_q[0];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = {$urandom, $urandom};
            end
        end
        if (stall_n > 0) bus.out_ready = (ov_ticks >= stall_n);
        else             bus.out_ready = (int'($urandom_range(99)) < p_out);
        #1;
        if (bus.avm_read) chk("rw_excl", 128'(bus.avm_write), 128'(0));
        if (hold_q)
            chk("beat_hold", 128'({bus.avm_write, bus.avm_read, bus.avm_byteenable,
                                   bus.avm_address, bus.avm_writedata}), 128'(snap));
        wr_acc = bus.avm_write && !bus.avm_waitrequest;
        if (wr_acc) begin
            wa  = bus.avm_address;
            wbe = bus.avm_byteenable;
            wd  = bus.avm_writedata;
            if (exp_beats.size() == 0) chk("beat_extra", 128'(bus.avm_write), 128'(0));
            else begin
                beat_t e;
                e = exp_beats.pop_front();
                chk("wr_beat", 128'({wa, wbe, wd}), 128'({e.a, e.be, e.d}));
            end
        end
        if (rd_out) chk("rd_one_out", 128'(bus.avm_read), 128'(0));
        if (bus.avm_read && !bus.avm_waitrequest) begin
            rd_addr = bus.avm_address;
            rd_pend = RD_LAT;
            rd_out  = 1'b1;
            if (exp_rd.size() == 0) chk("rd_extra", 128'(bus.avm_read), 128'(0));
            else chk("rd_addr", 128'(rd_addr), 128'(exp_rd.pop_front()));
        end
        if (bus.avm_write || bus.avm_read) bus_act++;
        in_acc = bus.in_valid && bus.in_ready;
        if (stall_q) chk("out_hold", 128'({bus.out_valid, bus.out_data}), 128'({1'b1, prev_out}));
        if (bus.out_valid && bus.out_ready) begin
            rd_out = 1'b0;
            if (exp_out.size() == 0) chk("out_extra", 128'(bus.out_valid), 128'(0));
            else chk("rd_data", 128'(bus.out_data), 128'(exp_out.pop_front()));
        end
        stall_q  = bus.out_valid && !bus.out_ready;
        prev_out = bus.out_data;
        ov_ticks = bus.out_valid ? ov_ticks + 1 : 0;
        hold_q   = (bus.avm_write || bus.avm_read) && bus.avm_waitrequest;
        snap     = {bus.avm_write, bus.avm_read, bus.avm_byteenable, bus.avm_address, bus.avm_writedata};
        if (bus.done) done_cnt++;
    endtask

    // Word-level expectations for one command; write data comes from wq first, then random.
    task automatic build_cmd(input bit wr, input logic [11:0] base, input logic [12:0] len);
        logic [11:0] a;
        logic [63:0] w;
        csum_exp = '0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 12'(i);
            if (wr) begin
                w = (wq.size() > 0) ? wq.pop_front() : {$urandom, $urandom};
                exp_beats.push_back('{a: a, be: 8'h0F, d: {32'h0, w[31:0]}});
                exp_beats.push_back('{a: a, be: 8'hF0, d: {w[63:32], 32'h0}});
                in_q.push_back(w);
                ref_mem[a] = w;
                csum_exp ^= w;
            end else begin
                exp_rd.push_back(a);
                exp_out.push_back(ref_mem[a]);
                csum_exp ^= ref_mem[a];
            end
        end
    endtask

    task automatic run_cmd(input bit wr, input logic [11:0] base, input logic [12:0] len, output int lat);
        int w;
        build_cmd(wr, base, len);
        done_cnt      = 0;
        bus.cmd_write = wr;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            tick();
            w++;
        end
        chk("cmd_ready_idle", 128'(bus.cmd_ready), 128'(1));
        bus_act = 0;
        lat     = 0;
        do begin
            tick();
            bus.cmd_valid = 1'b0;
            bus.cmd_base  = 12'($urandom);
            bus.cmd_len   = 13'($urandom);
            lat++;
            chk("cmd_ready_busy", 128'(bus.cmd_ready), 128'(0));
            if (!wr) chk("in_ready_rd", 128'(bus.in_ready), 128'(0));
        end while (done_cnt == 0 && lat < 4000);
        chk("done_seen", 128'(done_cnt), 128'(1));
`ifdef MSTR_CHECKSUM_EN
        chk("csum_done", 128'(csum), 128'(csum_exp));
`endif
        tick();
        chk("done_pulse", 128'({bus.done, bus.cmd_ready, done_cnt}), 128'({1'b0, 1'b1, 32'd1}));
`ifdef MSTR_CHECKSUM_EN
        chk("csum_hold", 128'(csum), 128'(csum_exp));
`endif
        chk("queues_empty", 128'({exp_beats.size(), exp_out.size(), exp_rd.size(), in_q.size()}), 128'(0));
    endtask

    initial begin
        #900_000;
        n_err++;
        $display("FAIL watchdog: got no finish by %0t expected finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        int lat;
        logic [11:0] rb;
        logic [12:0] rl;
        bit rw;
        bit found;
        for (int i = 0; i < 4096; i++) begin
            slave_mem[i] = {$urandom, $urandom};
            ref_mem[i]   = slave_mem[i];
        end
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        bus.avm_readdata = '0; bus.avm_waitrequest = 0;
        p_wait = 0; p_in = 100; p_out = 100; stall_n = 0; arm_wait = 0; force_wait = 0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_ctrl", 128'({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_byteenable,
                              bus.done, bus.in_ready, bus.out_valid, bus.cmd_ready}),
            128'({1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        chk("rst_wdata", 128'(bus.avm_writedata), 128'(0));
        chk("rst_odata", 128'(bus.out_data), 128'(0));
`ifdef MSTR_CHECKSUM_EN
        chk("rst_csum", 128'(csum), 128'(0));
`endif
        reset = 1'b0;

        wq.push_back(64'h1111_2222_3333_4444);
        wq.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        run_cmd(1'b1, 12'h010, 13'd2, lat);
        chk("s1_lat", 128'(lat), 128'(7));
        chk("s1_mem", 128'({slave_mem[12'h010], slave_mem[12'h011]}),
            128'({64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD}));
`ifdef MSTR_CHECKSUM_EN
        chk("s1_csum", 128'(csum), 128'(64'hBBBB_9999_FFFF_9999));
`endif

        run_cmd(1'b0, 12'h010, 13'd2, lat);
        chk("s2_lat", 128'(lat), 128'(1 + 2 * (2 + RD_LAT)));

        stall_n = 5;
        run_cmd(1'b0, 12'h010, 13'd3, lat);
        chk("s3_lat", 128'(lat), 128'(1 + 3 * (2 + RD_LAT + 5)));
        stall_n = 0;

        arm_wait = 3;
        run_cmd(1'b1, 12'hFFF, 13'd2, lat);
        chk("s4_lat", 128'(lat), 128'(10));
        run_cmd(1'b0, 12'hFFF, 13'd2, lat);

        run_cmd(1'b1, 12'h020, 13'd0, lat);
        chk("len0_wr", 128'({lat, bus_act}), 128'({32'd1, 32'd0}));
        run_cmd(1'b0, 12'h030, 13'd0, lat);
        chk("len0_rd", 128'({lat, bus_act}), 128'({32'd1, 32'd0}));

        p_wait = 25; p_in = 70; p_out = 70;
        repeat (40) begin
            rw = 1'($urandom_range(1));
            rb = ($urandom_range(3) == 0) ? 12'hFFC + 12'($urandom_range(3)) : 12'($urandom);
            rl = ($urandom_range(9) == 0) ? 13'd0 : 13'($urandom_range(6, 1));
            run_cmd(rw, rb, rl, lat);
        end

        p_wait = 0; p_in = 100; p_out = 100;
        build_cmd(1'b1, 12'h100, 13'd4);
        done_cnt = 0;
        bus.cmd_write = 1'b1; bus.cmd_base = 12'h100; bus.cmd_len = 13'd4; bus.cmd_valid = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            tick();
            bus.cmd_valid = 1'b0;
            found = bus.avm_write && (bus.avm_byteenable == 8'hF0);
        end
        chk("rst_reach_hi", 128'(found), 128'(1));
        reset = 1'b1;
        tick();
        chk("abort_ctrl", 128'({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_byteenable,
                                bus.done, bus.in_ready, bus.out_valid, bus.cmd_ready}),
            128'({1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        chk("abort_wdata", 128'(bus.avm_writedata), 128'(0));
        reset = 1'b0;
        bus.in_valid = 1'b0;
        in_q.delete();
        exp_beats.delete();
        repeat (4) tick();
        chk("abort_no_done", 128'(done_cnt), 128'(0));
`ifdef MSTR_CHECKSUM_EN
        chk("abort_csum", 128'(csum), 128'(0));
`endif
        run_cmd(1'b1, 12'h200, 13'd1, lat);
        run_cmd(1'b0, 12'h200, 13'd1, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
